// File: rtl/csr_exc_unit.sv
// ----------------------------------------------------------------------------
// csr_exc_unit
// Exception-consuming CSR block. Captures committed exceptions and ERTN
// from writeback, updates CRMD/PRMD/ESTAT/ERA/BADV, supplies exception and
// return entry addresses, owns the stable timer and reports pending enabled
// interrupts. One combinational read port and one masked write port serve
// csrrd/csrwr/csrxchg.
//
// Ports:
//   clk, reset                   core clock, synchronous active-high reset
//   csr_num                      CSR address shared by read and write
//   csr_rvalue                   combinational read data (0 if unimplemented)
//   csr_we/csr_wmask/csr_wvalue  masked write port
//   wb_ex/wb_ecode/wb_esubcode   committed exception report
//   wb_pc/wb_vaddr               faulting pc / faulting address
//   ertn_flush                   ERTN commit (dominates wb_ex)
//   hw_int_in/ipi_int_in         interrupt lines, sampled every cycle
//   has_int                      pending enabled interrupt (from registers)
//   ex_entry/ertn_entry          exception target pc / return pc
// ----------------------------------------------------------------------------
module csr_exc_unit #(
    parameter int unsigned TIMER_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [7:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic        has_int,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry
);

    localparam logic [13:0] CSR_CRMD      = 14'h0000;
    localparam logic [13:0] CSR_PRMD      = 14'h0001;
    localparam logic [13:0] CSR_ECFG      = 14'h0004;
    localparam logic [13:0] CSR_ESTAT     = 14'h0005;
    localparam logic [13:0] CSR_ERA       = 14'h0006;
    localparam logic [13:0] CSR_BADV      = 14'h0007;
    localparam logic [13:0] CSR_EENTRY    = 14'h000C;
    localparam logic [13:0] CSR_SAVE0     = 14'h0030;
    localparam logic [13:0] CSR_SAVE1     = 14'h0031;
    localparam logic [13:0] CSR_SAVE2     = 14'h0032;
    localparam logic [13:0] CSR_SAVE3     = 14'h0033;
    localparam logic [13:0] CSR_TID       = 14'h0040;
    localparam logic [13:0] CSR_TCFG      = 14'h0041;
    localparam logic [13:0] CSR_TVAL      = 14'h0042;
    localparam logic [13:0] CSR_TICLR     = 14'h0044;
    localparam logic [13:0] CSR_TLBRENTRY = 14'h0088;

    localparam logic [5:0]  ECODE_ADEF    = 6'h08;
    localparam logic [5:0]  ECODE_TLBR    = 6'h3F;

    // LIE bit 10 does not exist
    localparam logic [12:0] LIE_WMASK     = 13'h1BFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         plv_q, plv_d;
    logic               ie_q, ie_d;
    logic [1:0]         pplv_q, pplv_d;
    logic               pie_q, pie_d;
    logic [12:0]        lie_q, lie_d;
    logic [12:0]        is_q, is_d;
    logic [5:0]         ecode_q, ecode_d;
    logic [8:0]         esubcode_q, esubcode_d;
    logic [31:0]        era_q, era_d;
    logic [31:0]        badv_q, badv_d;
    logic [25:0]        eentry_q, eentry_d;
    logic [25:0]        tlbrentry_q, tlbrentry_d;
    logic [31:0]        save0_q, save0_d;
    logic [31:0]        save1_q, save1_d;
    logic [31:0]        save2_q, save2_d;
    logic [31:0]        save3_q, save3_d;
    logic [31:0]        tid_q, tid_d;
    logic [TIMER_W-1:0] tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;

    logic               csr_wr_en;
    logic [31:0]        wr_data;
    logic               tcfg_wr;
    logic               ticlr_clr;
    logic               timer_fire;
    logic [TIMER_W-1:0] tval_reload;

    // Software writes lose to any exception/ERTN commit in the same cycle
    assign csr_wr_en   = csr_we & ~wb_ex & ~ertn_flush;

    // Read-modify-write merge against the currently addressed CSR
    assign wr_data     = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);

    assign tval_reload = {tcfg_q[TIMER_W-1:2], 2'b00};

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        csr_rvalue = 32'h0;
        case (csr_num)
            CSR_CRMD:      csr_rvalue = {28'h0, 1'b1, ie_q, plv_q};
            CSR_PRMD:      csr_rvalue = {29'h0, pie_q, pplv_q};
            CSR_ECFG:      csr_rvalue = {19'h0, lie_q};
            CSR_ESTAT:     csr_rvalue = {1'b0, esubcode_q, ecode_q, 3'b000, is_q};
            CSR_ERA:       csr_rvalue = era_q;
            CSR_BADV:      csr_rvalue = badv_q;
            CSR_EENTRY:    csr_rvalue = {eentry_q, 6'h0};
            CSR_SAVE0:     csr_rvalue = save0_q;
            CSR_SAVE1:     csr_rvalue = save1_q;
            CSR_SAVE2:     csr_rvalue = save2_q;
            CSR_SAVE3:     csr_rvalue = save3_q;
            CSR_TID:       csr_rvalue = tid_q;
            CSR_TCFG:      csr_rvalue = 32'(tcfg_q);
            CSR_TVAL:      csr_rvalue = 32'(tval_q);
            CSR_TLBRENTRY: csr_rvalue = {tlbrentry_q, 6'h0};
            default:       csr_rvalue = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state: software writes, then exception/ERTN, interrupts, timer
    // ------------------------------------------------------------------
    always_comb begin
        plv_d       = plv_q;
        ie_d        = ie_q;
        pplv_d      = pplv_q;
        pie_d       = pie_q;
        lie_d       = lie_q;
        is_d        = is_q;
        ecode_d     = ecode_q;
        esubcode_d  = esubcode_q;
        era_d       = era_q;
        badv_d      = badv_q;
        eentry_d    = eentry_q;
        tlbrentry_d = tlbrentry_q;
        save0_d     = save0_q;
        save1_d     = save1_q;
        save2_d     = save2_q;
        save3_d     = save3_q;
        tid_d       = tid_q;
        tcfg_d      = tcfg_q;
        tval_d      = tval_q;
        tcfg_wr     = 1'b0;
        ticlr_clr   = 1'b0;
        timer_fire  = 1'b0;

        if (csr_wr_en) begin
            case (csr_num)
                CSR_CRMD: begin
                    plv_d = wr_data[1:0];
                    ie_d  = wr_data[2];
                end
                CSR_PRMD: begin
                    pplv_d = wr_data[1:0];
                    pie_d  = wr_data[2];
                end
                CSR_ECFG:      lie_d       = wr_data[12:0] & LIE_WMASK;
                CSR_ESTAT:     is_d[1:0]   = wr_data[1:0];
                CSR_ERA:       era_d       = wr_data;
                CSR_BADV:      badv_d      = wr_data;
                CSR_EENTRY:    eentry_d    = wr_data[31:6];
                CSR_SAVE0:     save0_d     = wr_data;
                CSR_SAVE1:     save1_d     = wr_data;
                CSR_SAVE2:     save2_d     = wr_data;
                CSR_SAVE3:     save3_d     = wr_data;
                CSR_TID:       tid_d       = wr_data;
                CSR_TLBRENTRY: tlbrentry_d = wr_data[31:6];
                CSR_TCFG: begin
                    tcfg_d  = wr_data[TIMER_W-1:0];
                    tcfg_wr = 1'b1;
                end
                // TICLR reads 0, so the merged value is just wvalue & wmask
                CSR_TICLR:     ticlr_clr   = wr_data[0];
                default: ;
            endcase
        end

        // ERTN also arrives with wb_ex raised; it must take priority
        if (ertn_flush) begin
            plv_d = pplv_q;
            ie_d  = pie_q;
        end else if (wb_ex) begin
            pplv_d     = plv_q;
            pie_d      = ie_q;
            plv_d      = 2'b00;
            ie_d       = 1'b0;
            ecode_d    = wb_ecode;
            esubcode_d = {1'b0, wb_esubcode};
            era_d      = wb_pc;
            case (wb_ecode)
                ECODE_ADEF:                    badv_d = wb_pc;
                6'h09, 6'h01, 6'h02, 6'h03,
                6'h04, 6'h07, ECODE_TLBR:      badv_d = wb_vaddr;
                default: ;
            endcase
        end

        // External and inter-processor interrupt lines are sampled each cycle
        is_d[9:2] = hw_int_in;
        is_d[12]  = ipi_int_in;

        // Timer: a TCFG write enabling the timer reloads and skips a decrement
        if (tcfg_wr && wr_data[0]) begin
            tval_d = {wr_data[TIMER_W-1:2], 2'b00};
        end else if (tcfg_q[0] && (tval_q != '0)) begin
            if (tval_q == TIMER_W'(1)) begin
                timer_fire = 1'b1;
                tval_d     = tcfg_q[1] ? tval_reload : '0;
            end else begin
                tval_d = tval_q - TIMER_W'(1);
            end
        end

        // Timer set wins over a same-cycle TICLR clear
        if (ticlr_clr) begin
            is_d[11] = 1'b0;
        end
        if (timer_fire) begin
            is_d[11] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            plv_q       <= '0;
            ie_q        <= 1'b0;
            pplv_q      <= '0;
            pie_q       <= 1'b0;
            lie_q       <= '0;
            is_q        <= '0;
            ecode_q     <= '0;
            esubcode_q  <= '0;
            era_q       <= '0;
            badv_q      <= '0;
            eentry_q    <= '0;
            tlbrentry_q <= '0;
            save0_q     <= '0;
            save1_q     <= '0;
            save2_q     <= '0;
            save3_q     <= '0;
            tid_q       <= '0;
            tcfg_q      <= '0;
            tval_q      <= '0;
        end else begin
            plv_q       <= plv_d;
            ie_q        <= ie_d;
            pplv_q      <= pplv_d;
            pie_q       <= pie_d;
            lie_q       <= lie_d;
            is_q        <= is_d;
            ecode_q     <= ecode_d;
            esubcode_q  <= esubcode_d;
            era_q       <= era_d;
            badv_q      <= badv_d;
            eentry_q    <= eentry_d;
            tlbrentry_q <= tlbrentry_d;
            save0_q     <= save0_d;
            save1_q     <= save1_d;
            save2_q     <= save2_d;
            save3_q     <= save3_d;
            tid_q       <= tid_d;
            tcfg_q      <= tcfg_d;
            tval_q      <= tval_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs derived from registers (ex_entry also selects on wb_ecode)
    // ------------------------------------------------------------------
    assign has_int    = ie_q & (|(is_q & lie_q));
    assign ex_entry   = (wb_ecode == ECODE_TLBR) ? {tlbrentry_q, 6'h0} : {eentry_q, 6'h0};
    assign ertn_entry = era_q;

endmodule
